// File: rtl/add8_err_monitor.sv
// Exhaustive error characterisation of a W-bit approximate adder.
// Sweeps every operand pair (A fastest, then B) into the adder under test.
// Compares each result with the exact sum and accumulates:
//   sum of absolute error, worst-case error, error count, Hamming-distance sum.
module add8_err_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  input  logic [W:0]       dut_o,
  output logic [3*W:0]     sum_abs_err,
  output logic [W:0]       max_abs_err,
  output logic [2*W:0]     err_count,
  output logic [2*W+4:0]   hd_sum
);

  localparam int unsigned SW = 3 * W + 1;
  localparam int unsigned CW = 2 * W + 1;
  localparam int unsigned HW = 2 * W + 5;
  localparam int unsigned PW = $clog2(W + 2);
  localparam logic [2:0]  DRAIN_LAST = (DUT_LAT == 0) ? 3'd0 : 3'(DUT_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2*W-1:0]  idx;
  logic            idx_last;
  logic            start_ok;
  logic [2:0]      drain_cnt;

  logic            vld0;
  logic [W:0]      exp0;
  logic            vld_s;
  logic [W:0]      exp_s;
  logic [W:0]      err_mag;
  logic [W:0]      diff_bits;
  logic [PW-1:0]   hd_cnt;

  // The registered operand pair doubles as the sweep index.
  assign idx      = {dut_b, dut_a};
  assign idx_last = &idx;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is ignored while a sweep or drain is running
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SWEEP;
      ST_SWEEP: if (idx_last) state_nxt = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_SWEEP;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == ST_SWEEP) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  // Operand generator: load 0 on start, step through all pairs, hold the last pair afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a <= '0;
      dut_b <= '0;
    end else if (start_ok) begin
      dut_a <= '0;
      dut_b <= '0;
    end else if ((state == ST_SWEEP) && !idx_last) begin
      {dut_b, dut_a} <= idx + 1'b1;
    end
  end

  // Drain cycle counter, restarted on every sweep cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  drain_cnt <= '0;
    else if (state == ST_SWEEP)  drain_cnt <= '0;
    else if (state == ST_DRAIN)  drain_cnt <= drain_cnt + 3'd1;
  end

  // Stage 0 of the compare pipeline: exact sum of the operands currently presented
  assign vld0 = (state == ST_SWEEP);
  assign exp0 = {1'b0, dut_a} + {1'b0, dut_b};

  // The expected sum and valid travel through the same number of registers as the adder result
  generate
    if (DUT_LAT == 0) begin : g_nodly
      assign vld_s = vld0;
      assign exp_s = exp0;
    end else begin : g_dly
      logic [DUT_LAT-1:0] vld_pipe;
      logic [W:0]         exp_pipe [DUT_LAT];

      // Delay line for expected sum and valid
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          for (int unsigned i = 0; i < DUT_LAT; i++) exp_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= vld0;
          exp_pipe[0] <= exp0;
          for (int unsigned i = 1; i < DUT_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
          end
        end
      end

      assign vld_s = vld_pipe[DUT_LAT-1];
      assign exp_s = exp_pipe[DUT_LAT-1];
    end
  endgenerate

  // Absolute error and Hamming distance of the sampled result
  always_comb begin
    err_mag   = (dut_o >= exp_s) ? (dut_o - exp_s) : (exp_s - dut_o);
    diff_bits = dut_o ^ exp_s;
    hd_cnt    = '0;
    for (int unsigned i = 0; i < W + 1; i++) hd_cnt = hd_cnt + PW'(diff_bits[i]);
  end

  // Figure-of-merit accumulators, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      hd_sum      <= '0;
    end else if (start_ok) begin
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      hd_sum      <= '0;
    end else if (vld_s) begin
      sum_abs_err <= sum_abs_err + SW'(err_mag);
      if (err_mag > max_abs_err) max_abs_err <= err_mag;
      err_count   <= err_count + CW'(err_mag != '0);
      hd_sum      <= hd_sum + HW'(hd_cnt);
    end
  end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Bench for add8_err_monitor.
// Four W=8 instances sweep in parallel against different adder behaviours:
//   exact, bit0-flipped, tied-to-zero, and a 3-cycle glitching adder.
// A W=4, DUT_LAT=2 instance covers the restart, mid-sweep reset and hold behaviour.
module tb_add8_err_monitor;

  typedef struct {
    longint sae;
    longint mae;
    longint cnt;
    longint hd;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0;
  logic rst_n, start, rst_s, start_s;

  always #5 clk = ~clk;

  // exact adder, latency 0
  logic [7:0]  a_e, b_e;
  logic [8:0]  o_e;
  logic [24:0] sae_e;
  logic [8:0]  mae_e;
  logic [16:0] cnt_e;
  logic [20:0] hd_e;
  logic        busy_e, done_e;
  assign o_e = {1'b0, a_e} + {1'b0, b_e};

  // bit0 inverted, latency 0
  logic [7:0]  a_1, b_1;
  logic [8:0]  o_1;
  logic [24:0] sae_1;
  logic [8:0]  mae_1;
  logic [16:0] cnt_1;
  logic [20:0] hd_1;
  logic        busy_1, done_1;
  assign o_1 = ({1'b0, a_1} + {1'b0, b_1}) ^ 9'd1;

  // tied to zero, latency 0
  logic [7:0]  a_z, b_z;
  logic [8:0]  o_z;
  logic [24:0] sae_z;
  logic [8:0]  mae_z;
  logic [16:0] cnt_z;
  logic [20:0] hd_z;
  logic        busy_z, done_z;
  assign o_z = '0;

  // exact except (255,255) -> 0, 3-stage register
  logic [7:0]  a_g, b_g;
  logic [8:0]  o_g, g_r1, g_r2, g_r3;
  logic [24:0] sae_g;
  logic [8:0]  mae_g;
  logic [16:0] cnt_g;
  logic [20:0] hd_g;
  logic        busy_g, done_g;
  always @(posedge clk) begin
    g_r1 <= ((a_g == 8'hFF) && (b_g == 8'hFF)) ? 9'd0 : ({1'b0, a_g} + {1'b0, b_g});
    g_r2 <= g_r1;
    g_r3 <= g_r2;
  end
  assign o_g = g_r3;

  // small W=4 OR-approximation adder, 2-stage register
  logic [3:0]  a_s, b_s;
  logic [4:0]  o_s, s_r1, s_r2;
  logic [12:0] sae_s;
  logic [4:0]  mae_s;
  logic [8:0]  cnt_s;
  logic [12:0] hd_s;
  logic        busy_s, done_s;
  always @(posedge clk) begin
    s_r1 <= {1'b0, a_s | b_s};
    s_r2 <= s_r1;
  end
  assign o_s = s_r2;

  add8_err_monitor #(.W(8), .DUT_LAT(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_e), .done(done_e),
    .dut_a(a_e), .dut_b(b_e), .dut_o(o_e), .sum_abs_err(sae_e),
    .max_abs_err(mae_e), .err_count(cnt_e), .hd_sum(hd_e));

  add8_err_monitor #(.W(8), .DUT_LAT(0)) u_bit0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_1), .done(done_1),
    .dut_a(a_1), .dut_b(b_1), .dut_o(o_1), .sum_abs_err(sae_1),
    .max_abs_err(mae_1), .err_count(cnt_1), .hd_sum(hd_1));

  add8_err_monitor #(.W(8), .DUT_LAT(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_z), .done(done_z),
    .dut_a(a_z), .dut_b(b_z), .dut_o(o_z), .sum_abs_err(sae_z),
    .max_abs_err(mae_z), .err_count(cnt_z), .hd_sum(hd_z));

  add8_err_monitor #(.W(8), .DUT_LAT(3)) u_glitch (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_g), .done(done_g),
    .dut_a(a_g), .dut_b(b_g), .dut_o(o_g), .sum_abs_err(sae_g),
    .max_abs_err(mae_g), .err_count(cnt_g), .hd_sum(hd_g));

  add8_err_monitor #(.W(4), .DUT_LAT(2)) u_small (
    .clk(clk), .rst_n(rst_s), .start(start_s), .busy(busy_s), .done(done_s),
    .dut_a(a_s), .dut_b(b_s), .dut_o(o_s), .sum_abs_err(sae_s),
    .max_abs_err(mae_s), .err_count(cnt_s), .hd_sum(hd_s));

  // Reference figures from a direct walk over all operand pairs
  function automatic res_t model(input int w, input int mode);
    res_t r;
    int   s, o, e;
    r.sae = 0; r.mae = 0; r.cnt = 0; r.hd = 0;
    for (int a = 0; a < (1 << w); a++) begin
      for (int b = 0; b < (1 << w); b++) begin
        s = a + b;
        case (mode)
          0:       o = s;
          1:       o = s ^ 1;
          2:       o = 0;
          3:       o = (a == 255 && b == 255) ? 0 : s;
          default: o = a | b;
        endcase
        e = (o > s) ? o - s : s - o;
        r.sae += e;
        if (e > r.mae) r.mae = e;
        if (e != 0) r.cnt++;
        r.hd += $countones(o ^ s);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_res(input string tag, input longint sae, input longint mae,
                           input longint cnt, input longint hd);
    res_t r;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      r = exp_q.pop_front();
      chk({tag, "_sum_abs_err"}, sae, r.sae);
      chk({tag, "_max_abs_err"}, mae, r.mae);
      chk({tag, "_err_count"},   cnt, r.cnt);
      chk({tag, "_hd_sum"},      hd,  r.hd);
    end
  endtask

  task automatic pulse_s();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic wait_small(output int n);
    n = 0;
    while (busy_s && n < 2000) begin
      n++;
      tick();
    end
  endtask

  int n_s, n0, n3, guard;

  initial begin
    rst_n = 1'b0; rst_s = 1'b0; start = 1'b0; start_s = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; rst_s = 1'b1;
    tick();

    // reset state
    chk("rst_busy",  busy_e, 0);
    chk("rst_done",  done_e, 0);
    chk("rst_dut_a", a_e, 0);
    chk("rst_dut_b", b_e, 0);
    chk("rst_sae",   sae_g, 0);
    chk("rst_cnt",   cnt_z, 0);
    chk("rst_small_busy", busy_s, 0);

    // small run 1
    exp_q.push_back(model(4, 4));
    pulse_s();
    chk("s1_busy_after_start", busy_s, 1);
    wait_small(n_s);
    chk("s1_busy_cycles", n_s, 258);
    chk("s1_done", done_s, 1);
    check_res("s1", sae_s, mae_s, cnt_s, hd_s);
    chk("s1_hold_a", a_s, 15);
    chk("s1_hold_b", b_s, 15);
    repeat (3) tick();
    chk("s1_done_held", done_s, 1);
    chk("s1_hold_a_later", a_s, 15);

    // back-to-back restart from DONE
    exp_q.push_back(model(4, 4));
    pulse_s();
    chk("s2_done_drop", done_s, 0);
    chk("s2_busy", busy_s, 1);
    chk("s2_sae_clr", sae_s, 0);
    chk("s2_mae_clr", mae_s, 0);
    chk("s2_cnt_clr", cnt_s, 0);
    chk("s2_hd_clr",  hd_s, 0);
    wait_small(n_s);
    chk("s2_busy_cycles", n_s, 258);
    check_res("s2", sae_s, mae_s, cnt_s, hd_s);

    // asynchronous reset mid-sweep
    pulse_s();
    repeat (100) tick();
    chk("s3_midsweep_busy", busy_s, 1);
    rst_s = 1'b0;
    #1;
    chk("s3_rst_busy", busy_s, 0);
    chk("s3_rst_done", done_s, 0);
    chk("s3_rst_a", a_s, 0);
    chk("s3_rst_b", b_s, 0);
    chk("s3_rst_sae", sae_s, 0);
    chk("s3_rst_hd",  hd_s, 0);
    tick();
    rst_s = 1'b1;
    repeat (3) tick();
    chk("s3_idle_busy", busy_s, 0);
    chk("s3_idle_done", done_s, 0);
    exp_q.push_back(model(4, 4));
    pulse_s();
    wait_small(n_s);
    chk("s4_busy_cycles", n_s, 258);
    check_res("s4", sae_s, mae_s, cnt_s, hd_s);

    // full W=8 sweeps in parallel, with a stray start at idx=1000
    exp_q.push_back(model(8, 0));
    exp_q.push_back(model(8, 1));
    exp_q.push_back(model(8, 2));
    exp_q.push_back(model(8, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = 0; n3 = 0; guard = 0;
    while ((busy_e || busy_g) && guard < 70000) begin
      if (busy_e) n0++;
      if (busy_g) n3++;
      start = ({b_e, a_e} == 16'd1000);
      guard++;
      tick();
    end
    start = 1'b0;
    chk("big_busy_lat0", n0, 65536);
    chk("big_busy_lat3", n3, 65539);
    chk("big_done_exact",  done_e, 1);
    chk("big_done_glitch", done_g, 1);
    chk("big_done_bit0",   done_1, 1);
    chk("big_done_zero",   done_z, 1);
    check_res("exact",  sae_e, mae_e, cnt_e, hd_e);
    check_res("bit0",   sae_1, mae_1, cnt_1, hd_1);
    check_res("zero",   sae_z, mae_z, cnt_z, hd_z);
    check_res("glitch", sae_g, mae_g, cnt_g, hd_g);
    chk("big_hold_a", a_g, 255);
    chk("big_hold_b", b_g, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add8_err_monitor.md
Name: add8_err_monitor

Overview:
- Exhaustive error-characterization engine for 8-bit approximate adders in the library.
- Drives every operand pair (A,B) into an adder under test and reads back its 9-bit result O.
- Compares each result against the exact sum and accumulates the library's figures of merit: sum of absolute error (→MAE), worst-case error, error count (→EP) and Hamming-distance sum (→HD).
- Sits on the consumer side of the adder interface, in the characterization/regression bench harness and on FPGA self-test builds.

Parameters:
- W, 8, operand width; result width W+1; sweep length 2^(2W).
- DUT_LAT, 0, clock cycles from dut_a/dut_b change to a valid dut_o (0 = combinational DUT); legal range 0..7.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep
- busy  output  1  sweep in progress
- done  output  1  results valid; held until next start or reset
- dut_a  output  W  operand A to the adder under test (registered)
- dut_b  output  W  operand B to the adder under test (registered)
- dut_o  input  W+1  result from the adder under test
- sum_abs_err  output  3W+1  Σ|dut_o − (a+b)|
- max_abs_err  output  W+1  max |dut_o − (a+b)|
- err_count  output  2W+1  number of pairs with dut_o ≠ a+b
- hd_sum  output  2W+5  Σ popcount(dut_o XOR (a+b))

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy=0, done=0, dut_a=0, dut_b=0, all accumulators 0, delay line cleared.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE/DONE + start=1 → SWEEP next cycle.
  - In that same transition: clear all accumulators, idx=0, done=0, busy=1.
  - SWEEP: dut_a=idx[W-1:0], dut_b=idx[2W-1:W]; idx increments by 1 each cycle (A fastest).
  - At idx=2^(2W)−1: if DUT_LAT=0, go to DONE next cycle; else go to DRAIN.
  - DRAIN: hold the last operands for DUT_LAT cycles, then go to DONE.
  - DONE: busy=0, done=1.
- Compare pipeline:
  - Expected sum exp=a+b (W+1 bits, exact) and a valid bit are delayed DUT_LAT cycles alongside the operands.
  - On each clock edge where the delayed valid=1, sample dut_o and compute:
    - e = |dut_o − exp| (W+1 bits, unsigned magnitude)
    - sum_abs_err += e
    - max_abs_err = max(max_abs_err, e)
    - err_count += (e≠0)
    - hd_sum += popcount(dut_o^exp)
- Exactly 2^(2W) samples per sweep; no sample is taken in IDLE or DONE.
- busy is high for exactly 2^(2W)+DUT_LAT cycles.
- Widths are sized so no accumulator can overflow for any dut_o; no saturation logic.
- start while busy=1 is ignored; it has no effect on the running sweep.
- start in DONE restarts: results are cleared on the same edge and done drops.
- Accumulator outputs are live during SWEEP; they are only guaranteed final when done=1.
- rst_n asserted mid-sweep: immediate return to reset values; no partial results are retained.
- dut_a/dut_b hold their last values in DONE; they return to 0 only on reset.

Test Plan:
- Exact loopback (dut_o=dut_a+dut_b, DUT_LAT=0), start pulse → done after 65536 busy cycles; sum_abs_err=0, max_abs_err=0, err_count=0, hd_sum=0.
- dut_o = exact sum with bit0 inverted → sum_abs_err=65536, max_abs_err=1, err_count=65536, hd_sum=65536.
- dut_o tied to 0 → sum_abs_err=16711680, max_abs_err=510, err_count=65535.
- dut_o exact except (A=255,B=255) returns 0, DUT_LAT=3 with a 3-stage register on the bench → busy for 65539 cycles; sum_abs_err=510, max_abs_err=510, err_count=1, hd_sum=8.
- start re-pulsed at idx=1000 is ignored (counts unchanged vs. the clean run); rst_n pulsed at idx=30000 → all outputs 0 and state IDLE; a fresh start then yields clean results.
- Back-to-back runs: start in DONE → done falls, accumulators read 0 on the next cycle, and the second run's results match the first.
